cache_evict_ctrl: RTL and testbench

CACHE_EVICT_CTRL -- requirements
Module: cache_evict_ctrl

---
 rtl/cache_evict_ctrl.sv | 149 ++++++++++++++
 tb/tb_cache_evict_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_evict_ctrl.sv
// Purpose: miss-service sequencer choosing a victim way, writing back dirty lines, refilling and updating LRU.
// Latency: 4 cycles miss-to-done minimum (IDLE, SELECT, FILL with immediate pmem_resp, UPDATE).
// Backpressure: memory requests are level-held until pmem_resp; miss is held by the datapath until done.
module cache_evict_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss,
    input  logic [3:0]       valid,
    input  logic [3:0]       dirty,
    input  logic [1:0]       lru_way,
    input  logic             pmem_resp,
    output logic             lru_read,
    output logic             lru_load,
    output logic [3:0]       lru_hit,
    output logic [1:0]       victim_way,
    output logic             wb_sel,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [3:0]       way_load,
    output logic             done,
    output logic [CNT_W-1:0] evict_cnt,
    output logic [CNT_W-1:0] wb_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SELECT    = 3'd1,
        S_WRITEBACK = 3'd2,
        S_FILL      = 3'd3,
        S_UPDATE    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [1:0]       victim_q, victim_d;
    logic [CNT_W-1:0] evict_cnt_q, evict_cnt_d;
    logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

    logic [1:0]       pick_way;
    logic             pick_found;
    logic             pick_valid;
    logic             pick_dirty;
    logic [3:0]       victim_oh;

    // Victim choice: first empty way wins; LRU only decides when the set is full.
    always_comb begin
        pick_way   = lru_way;
        pick_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!pick_found && !valid[i]) begin
                pick_way   = 2'(i);
                pick_found = 1'b1;
            end
        end
        pick_valid = valid[pick_way];
        pick_dirty = dirty[pick_way];
        victim_oh  = 4'b0001 << victim_q;
    end

    // State, victim and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            victim_q    <= 2'd0;
            evict_cnt_q <= '0;
            wb_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            victim_q    <= victim_d;
            evict_cnt_q <= evict_cnt_d;
            wb_cnt_q    <= wb_cnt_d;
        end
    end

    // Next-state, victim capture and saturating counter updates.
    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        evict_cnt_d = evict_cnt_q;
        wb_cnt_d    = wb_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (miss) state_d = S_SELECT;
            end
            S_SELECT: begin
                victim_d = pick_way;
                state_d  = (pick_valid && pick_dirty) ? S_WRITEBACK : S_FILL;
                if (pick_valid && (evict_cnt_q != CNT_MAX))
                    evict_cnt_d = evict_cnt_q + CNT_W'(1);
            end
            S_WRITEBACK: begin
                if (pmem_resp) begin
                    state_d = S_FILL;
                    if (wb_cnt_q != CNT_MAX)
                        wb_cnt_d = wb_cnt_q + CNT_W'(1);
                end
            end
            S_FILL: begin
                if (pmem_resp) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes decode from the current state only, so reset clears them at once.
    always_comb begin
        lru_read   = 1'b0;
        lru_load   = 1'b0;
        lru_hit    = 4'b0000;
        wb_sel     = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        way_load   = 4'b0000;
        done       = 1'b0;
        case (state_q)
            S_SELECT: begin
                lru_read = 1'b1;
            end
            S_WRITEBACK: begin
                pmem_write = 1'b1;
                wb_sel     = 1'b1;
            end
            S_FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) way_load = victim_oh;
            end
            S_UPDATE: begin
                lru_load = 1'b1;
                lru_hit  = victim_oh;
                done     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign victim_way = victim_q;
    assign evict_cnt  = evict_cnt_q;
    assign wb_cnt     = wb_cnt_q;

endmodule

// File: tb/tb_cache_evict_ctrl.sv
// Purpose: directed scoreboard bench for cache_evict_ctrl with a latency-programmable memory responder.
// Latency: expectations pushed at miss issue, popped by the monitor on each done pulse.
// Backpressure: memory responder answers after mem_lat request cycles.
module tb_cache_evict_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          miss;
    logic [3:0]    valid;
    logic [3:0]    dirty;
    logic [1:0]    lru_way;
    logic          pmem_resp;
    logic          resp_gen;
    logic          spur_resp;
    logic          lru_read;
    logic          lru_load;
    logic [3:0]    lru_hit;
    logic [1:0]    victim_way;
    logic          wb_sel;
    logic          pmem_read;
    logic          pmem_write;
    logic [3:0]    way_load;
    logic          done;
    logic [CW-1:0] evict_cnt;
    logic [CW-1:0] wb_cnt;

    assign pmem_resp = resp_gen | spur_resp;

    cache_evict_ctrl #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .miss       (miss),
        .valid      (valid),
        .dirty      (dirty),
        .lru_way    (lru_way),
        .pmem_resp  (pmem_resp),
        .lru_read   (lru_read),
        .lru_load   (lru_load),
        .lru_hit    (lru_hit),
        .victim_way (victim_way),
        .wb_sel     (wb_sel),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .way_load   (way_load),
        .done       (done),
        .evict_cnt  (evict_cnt),
        .wb_cnt     (wb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int mem_lat = 1;

    typedef struct {
        int victim;
        int oh;
        int rd;
        int wr;
        int gap;
        int ev;
        int wbc;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic push_exp(input int victim, input int lat, input bit wb,
                            input int gap, input int ev, input int wbc);
        exp_t e;
        e.victim = victim;
        e.oh     = 1 << victim;
        e.rd     = lat;
        e.wr     = wb ? lat : 0;
        e.gap    = gap;
        e.ev     = ev;
        e.wbc    = wbc;
        sb_q.push_back(e);
    endtask

    // Memory model: answers each request after mem_lat cycles of request.
    initial begin
        int req_n;
        req_n    = 0;
        resp_gen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            resp_gen = 1'b0;
            if (rst) begin
                req_n = 0;
            end else if (pmem_read || pmem_write) begin
                req_n++;
                if (req_n >= mem_lat) begin
                    resp_gen = 1'b1;
                    req_n    = 0;
                end
            end else begin
                req_n = 0;
            end
        end
    end

    // Monitor: accumulates per-operation behaviour, compares against scoreboard on done.
    initial begin
        int cyc, last_done, t_sel, t_rd, t_wr, t_ovl, t_bad, t_wlc, t_wl;
        exp_t e;
        cyc = 0; last_done = -100; t_sel = 0;
        t_rd = 0; t_wr = 0; t_ovl = 0; t_bad = 0; t_wlc = 0; t_wl = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                t_rd = 0; t_wr = 0; t_ovl = 0; t_bad = 0; t_wlc = 0; t_wl = 0;
                last_done = -100;
            end else begin
                if (lru_read) t_sel = cyc;
                if (pmem_read) t_rd++;
                if (pmem_write) t_wr++;
                if (pmem_read && pmem_write) t_ovl++;
                if ((pmem_write && !wb_sel) || (pmem_read && wb_sel)) t_bad++;
                if (way_load != 4'b0000) begin
                    t_wlc++;
                    t_wl = int'(way_load);
                end
                if (done) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: done pulse at cycle %0d with no pending miss", cyc);
                    end else begin
                        e = sb_q.pop_front();
                        chk("victim_way", int'(victim_way), e.victim);
                        chk("lru_hit", int'(lru_hit), e.oh);
                        chk("lru_load", int'(lru_load), 1);
                        chk("way_load", t_wl, e.oh);
                        chk("way_load_pulses", t_wlc, 1);
                        chk("pmem_read_cycles", t_rd, e.rd);
                        chk("pmem_write_cycles", t_wr, e.wr);
                        chk("rd_wr_overlap", t_ovl, 0);
                        chk("wb_sel_mismatch", t_bad, 0);
                        chk("evict_cnt", int'(evict_cnt), e.ev);
                        chk("wb_cnt", int'(wb_cnt), e.wbc);
                        if (e.gap >= 0) chk("idle_gap", t_sel - last_done, e.gap);
                    end
                    last_done = cyc;
                    t_rd = 0; t_wr = 0; t_ovl = 0; t_bad = 0; t_wlc = 0; t_wl = 0;
                end
            end
        end
    end

    // Issue one miss from IDLE (called at a negedge) and wait for its done.
    task automatic do_miss(input logic [3:0] v, input logic [3:0] d, input logic [1:0] l,
                           input int lat, input int victim, input bit wb,
                           input int ev, input int wbc, input bit drop_fill, input bit chk_lat);
        int n;
        mem_lat = lat;
        valid   = v;
        dirty   = d;
        lru_way = l;
        push_exp(victim, lat, wb, -1, ev, wbc);
        miss = 1'b1;
        n    = 1;
        @(negedge clk);
        n++;
        chk("select_after_one_edge", int'(lru_read), 1);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (drop_fill && pmem_read) miss = 1'b0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end
        if (chk_lat) chk("miss_to_done_cycles", n, 4);
        miss = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; miss = 1'b0; valid = 4'b0; dirty = 4'b0; lru_way = 2'd0;
        spur_resp = 1'b0;
        #1;
        chk("rst_strobes", int'({lru_read, lru_load, wb_sel, pmem_read, pmem_write, done}), 0);
        chk("rst_vectors", int'({lru_hit, way_load}), 0);
        chk("rst_victim", int'(victim_way), 0);
        chk("rst_evict_cnt", int'(evict_cnt), 0);
        chk("rst_wb_cnt", int'(wb_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Cold miss: first invalid way 0, minimum latency.
        do_miss(4'b0000, 4'b0000, 2'd2, 1, 0, 1'b0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        // Full set, LRU way 2 dirty: writeback then fill.
        do_miss(4'b1111, 4'b0100, 2'd2, 1, 2, 1'b1, 1, 1, 1'b0, 1'b0);
        @(negedge clk);
        // Full clean set, slow memory.
        do_miss(4'b1111, 4'b0000, 2'd3, 10, 3, 1'b0, 2, 1, 1'b0, 1'b0);
        @(negedge clk);
        // Invalid way 2 is chosen even though dirty bits are set.
        do_miss(4'b1011, 4'b1111, 2'd0, 2, 2, 1'b0, 2, 1, 1'b0, 1'b0);
        @(negedge clk);
        // Only way 3 empty.
        do_miss(4'b0111, 4'b0000, 2'd1, 1, 3, 1'b0, 2, 1, 1'b0, 1'b0);
        @(negedge clk);

        // Spurious response in IDLE must not start anything.
        spur_resp = 1'b1;
        @(negedge clk);
        spur_resp = 1'b0;
        chk("idle_spur_strobes",
            int'({lru_read, pmem_read, pmem_write, done, way_load}), 0);
        @(negedge clk);
        chk("idle_spur_evict_cnt", int'(evict_cnt), 2);
        // Dirty eviction with miss dropped during FILL still completes once.
        do_miss(4'b1111, 4'b0010, 2'd1, 3, 1, 1'b1, 3, 2, 1'b1, 1'b0);
        @(negedge clk);

        // Back-to-back: miss held past done is re-accepted after one IDLE cycle.
        mem_lat = 1; valid = 4'b0000; dirty = 4'b0000; lru_way = 2'd1;
        push_exp(0, 1, 1'b0, -1, 3, 2);
        push_exp(0, 1, 1'b0, 2, 3, 2);
        miss = 1'b1;
        n = 0;
        while (!done && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        n = 0;
        while (!done && n < 50) begin @(negedge clk); n++; end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL b2b_timeout: got no second done expected done");
        end
        miss = 1'b0;
        @(negedge clk);

        // Reset during WRITEBACK: memory write drops immediately, no done.
        mem_lat = 20; valid = 4'b1111; dirty = 4'b1000; lru_way = 2'd3;
        miss = 1'b1;
        n = 0;
        while (!pmem_write && n < 20) begin @(negedge clk); n++; end
        chk("wb_reached", int'(pmem_write), 1);
        miss = 1'b0;
        repeat (2) @(negedge clk);
        chk("ev_before_rst", int'(evict_cnt), 4);
        chk("victim_before_rst", int'(victim_way), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_wb_pmem_write", int'(pmem_write), 0);
        chk("rst_mid_wb_strobes", int'({lru_read, pmem_read, done, lru_load}), 0);
        chk("rst_mid_wb_victim", int'(victim_way), 0);
        chk("rst_mid_wb_evict_cnt", int'(evict_cnt), 0);
        chk("rst_mid_wb_wb_cnt", int'(wb_cnt), 0);
        repeat (2) @(negedge clk);
        chk("rst_hold_idle", int'({pmem_write, pmem_read, lru_read, done}), 0);
        rst = 1'b0;
        // First miss after reset release is taken on the next edge.
        do_miss(4'b0000, 4'b0000, 2'd0, 1, 0, 1'b0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);

        // Drive the 4-bit evict counter into saturation with clean evictions.
        for (int i = 0; i < 16; i++) begin
            do_miss(4'b1111, 4'b0000, 2'(i % 4), 1, i % 4, 1'b0,
                    (i + 1 > 15) ? 15 : i + 1, 0, 1'b0, 1'b0);
            @(negedge clk);
        end
        // Dirty eviction at saturation: evict_cnt holds, wb_cnt increments.
        do_miss(4'b1111, 4'b1111, 2'd1, 1, 1, 1'b1, 15, 1, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
